rat_reduce: RTL and testbench
=============================

# rat_reduce

Iterative reducer that brings an unsigned rational (num/den) to lowest terms. It sits directly downstream of the rational `mul` stage and consumes its raw `s_num`/`s_den` product. It computes gcd(num, den) with the binary (Stein) algorithm, then divides both terms by the gcd with shift-subtract division. A valid/ready handshake on both sides lets it absorb the variable latency.

## Interface
- `WIDTH`, 32, bit width of numerator, denominator and all internal operands.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input rational presented.
- `in_ready`  out  1  block can accept an input (IDLE only).
- `in_num`  in  WIDTH  unreduced numerator.
- `in_den`  in  WIDTH  unreduced denominator.
- `out_valid`  out  1  reduced result held on outputs.
- `out_ready`  in  1  consumer accepts result.
- `s_num`  out  WIDTH  reduced numerator.
- `s_den`  out  WIDTH  reduced denominator.
- `err`  out  1  zero-denominator flag (see Configuration).

## Operation
- Accept an input on a cycle where `in_valid && in_ready`. Register `in_num`/`in_den` that cycle.
- States: IDLE → (CHECK) → TWOS → GCD → DIV → DONE → IDLE.
- **CHECK** (one cycle) applies these fast paths:
  - num==0, den!=0 → result (0,1), go DONE.
  - num==0, den==0 → result (0,0), go DONE.
  - den==0, num!=0 → result (1,0), go DONE.
  - Otherwise go TWOS.
- **TWOS**: while a and b are both even, shift both right by 1 and increment k (log2(WIDTH)+1 bits). One shift per cycle.
- **GCD**: each cycle performs exactly one action, in this order:
  - if b==0 → g = a<<k, go DIV;
  - else if a even → a>>=1;
  - else if b even → b>>=1;
  - else if a>b → (a,b) ← (b, a−b);
  - else b ← b−a.
- **DIV**: two parallel restoring dividers compute num/g and den/g. Each takes exactly WIDTH cycles. The division is always exact, so remainders are discarded.
- **DONE**: assert `out_valid` and hold `s_num`/`s_den`/`err` stable until `out_ready`. The handshake cycle returns the block to IDLE.
- All arithmetic is unsigned WIDTH-bit with no overflow possible: a, b ≤ max(num, den), and the quotient ≤ dividend.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `s_num`=0, `s_den`=0, `err`=0, state IDLE. Internal a, b, k are cleared.
- Reset mid-operation aborts immediately. The in-flight operand is dropped and no output is produced.
- `in_ready` is 1 only in IDLE. It drops the cycle after acceptance, so there is no back-to-back acceptance.
- Fast-path latency, accept to `out_valid`: 2 cycles.
- General latency: 1 (CHECK) + T (TWOS, ≤ WIDTH) + G (GCD, ≤ 2·WIDTH+1) + WIDTH (DIV) + 1 cycles.
- Worst-case bound, which the bench asserts: 4·WIDTH+4 cycles.
- `out_valid` may sit high indefinitely. Outputs must not change while `out_valid && !out_ready`.
- `in_valid` while busy is ignored, not queued.

## Configuration
- `RAT_REDUCE_DIVZERO_EN` defined:
  - den==0 takes the CHECK fast path.
  - `err`=1 in DONE.
  - `s_num`/`s_den` pass the input through unchanged.
- `RAT_REDUCE_DIVZERO_EN` undefined:
  - `err` is tied to 0.
  - den==0 produces the results listed under Operation: (1,0), or (0,0) when num is also 0.

## Structure
- Shared package `rat_pkg` holds:
  - the state enum (IDLE, CHECK, TWOS, GCD, DIV, DONE);
  - the default WIDTH constant;
  - the fast-path constants ZERO_NUM_DEN=1 and ZERO_DEN_NUM=1.
- One sub-module, `rat_divu`: a WIDTH-cycle restoring divider with start/done. It is instantiated twice, once for num and once for den. GCD and TWOS logic stay inline in `rat_reduce`.

## Test plan
- (12,18) → (2,3), `err`=0, latency ≤ 4·WIDTH+4.
- (60,60), the `mul` product of (6/4)·(10/15) → (1,1). Also (7,13) → (7,13), coprime, unchanged.
- (0,5) → (0,1) two cycles after accept. (1024,4096) → (1,4), exercising TWOS k=10.
- (9,0):
  - with `RAT_REDUCE_DIVZERO_EN` → (9,0), `err`=1;
  - without → (1,0), `err`=0.
- Backpressure: result for (999000,998001) is (1000,999). Hold `out_ready`=0 for 10 cycles. Outputs are stable, `in_ready`=0, and a pulsed `in_valid` is ignored.
- Assert `rst` mid-GCD on (360,840) → `out_valid`=0 and `in_ready`=1 immediately. The next input (8,12) → (2,3).

Source files
------------

// File: rtl/rat_pkg.sv
// Shared definitions for the rational reducer: controller states, the default
// operand width and the constant terms written by the zero fast paths.
package rat_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // Denominator produced when the numerator is zero, so that 0/x becomes 0/1.
  localparam int ZERO_NUM_DEN = 1;

  // Numerator produced when only the denominator is zero, so that x/0 becomes 1/0.
  localparam int ZERO_DEN_NUM = 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    TWOS,
    GCD,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/rat_divu.sv
// Restoring unsigned divider. A start pulse loads the operands, and then one
// quotient bit is produced per cycle for WIDTH cycles. 'done' is high during
// the final step. 'quotient' is the value that step produces, so the caller
// can capture the result on the same edge that completes the division.
module rat_divu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem, quo, div_r, rem_next, quo_next;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [CW-1:0]    cnt;

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  // The partial remainder stays below the divisor, so the true difference fits in WIDTH bits.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    fits     = shifted >= {1'b0, div_r};
    rem_next = fits ? (shifted[WIDTH-1:0] - div_r) : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

  assign done     = (cnt == CW'(1));
  assign quotient = quo_next;

  // Operand load on start, then WIDTH iterations counted down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      div_r <= '0;
      cnt   <= '0;
    end else if (start) begin
      rem   <= '0;
      quo   <= dividend;
      div_r <= divisor;
      cnt   <= CW'(WIDTH);
    end else if (cnt != '0) begin
      rem <= rem_next;
      quo <= quo_next;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/rat_reduce.sv
// Rational reducer: it brings num/den to lowest terms. The binary GCD runs
// inline, in two phases: it first strips the common factors of two, then it
// runs the Stein reduction. Two rat_divu instances then divide both terms by
// the GCD. Define RAT_REDUCE_DIVZERO_EN to flag zero denominators on 'err' and
// to pass those operands through unchanged. Without it, 'err' is tied low.
module rat_reduce
  import rat_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s_num,
  output logic [WIDTH-1:0] s_den,
  output logic             err
);

  localparam int KW = $clog2(WIDTH) + 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] num_r, den_r, a, b, g, num_q, den_q;
  logic [KW-1:0]    k;
  logic             div_start, num_done, den_done, fast_path;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign g         = a << k;
  assign fast_path = (num_r == '0) || (den_r == '0);

  // Controller state register; reset drops any in-flight operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state sequencing and the divider launch pulse.
  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    case (state)
      IDLE:  if (in_valid) state_next = CHECK;
      CHECK: state_next = fast_path ? DONE : TWOS;
      TWOS:  if (a[0] || b[0]) state_next = GCD;
      GCD:   if (b == '0) begin
               state_next = DIV;
               div_start  = 1'b1;
             end
      DIV:   if (num_done && den_done) state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, zero fast paths, common-twos removal, Stein steps and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_r <= '0;
      den_r <= '0;
      a     <= '0;
      b     <= '0;
      k     <= '0;
      s_num <= '0;
      s_den <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          num_r <= in_num;
          den_r <= in_den;
          a     <= in_num;
          b     <= in_den;
          k     <= '0;
        end
        CHECK: begin
`ifdef RAT_REDUCE_DIVZERO_EN
          if (den_r == '0) begin
            s_num <= num_r;
            s_den <= den_r;
          end else if (num_r == '0) begin
            s_num <= '0;
            s_den <= WIDTH'(ZERO_NUM_DEN);
          end
`else
          if (num_r == '0) begin
            s_num <= '0;
            s_den <= (den_r == '0) ? '0 : WIDTH'(ZERO_NUM_DEN);
          end else if (den_r == '0) begin
            s_num <= WIDTH'(ZERO_DEN_NUM);
            s_den <= '0;
          end
`endif
        end
        TWOS: if (!a[0] && !b[0]) begin
          a <= a >> 1;
          b <= b >> 1;
          k <= k + KW'(1);
        end
        GCD: begin
          if (b == '0) begin
            a <= a;
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a > b) begin
            a <= b;
            b <= a - b;
          end else begin
            b <= b - a;
          end
        end
        DIV: if (num_done && den_done) begin
          s_num <= num_q;
          s_den <= den_q;
        end
        default: ;
      endcase
    end
  end

`ifdef RAT_REDUCE_DIVZERO_EN
  // The zero-denominator flag is decided once, in CHECK, and then held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err <= 1'b0;
    else if (state == CHECK) err <= (den_r == '0);
  end
`else
  assign err = 1'b0;
`endif

  rat_divu #(.WIDTH(WIDTH)) u_div_num (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (num_r),
    .divisor  (g),
    .done     (num_done),
    .quotient (num_q)
  );

  rat_divu #(.WIDTH(WIDTH)) u_div_den (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (den_r),
    .divisor  (g),
    .done     (den_done),
    .quotient (den_q)
  );

endmodule

// File: tb/tb_rat_reduce.sv
// Directed bench for rat_reduce. Expected results come from a Euclid-based
// reference model and are queued when an operand is accepted. They are popped
// and compared when the DUT presents its result.
module tb_rat_reduce;

  localparam int W = 32;
  localparam int MAX_LAT = 4 * W + 4;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [W-1:0] in_num, in_den, s_num, s_den;

  exp_t sb[$];
  int   checks, errors;

  rat_reduce #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_num    (in_num),
    .in_den    (in_den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_num     (s_num),
    .s_den     (s_den),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] refGcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic exp_t refModel(input logic [W-1:0] n, input logic [W-1:0] d);
    exp_t r;
    logic [W-1:0] g;
    r.e = 1'b0;
    if (d == 0) begin
`ifdef RAT_REDUCE_DIVZERO_EN
      r.n = n; r.d = d; r.e = 1'b1;
`else
      r.n = (n == 0) ? 0 : 1; r.d = 0;
`endif
    end else if (n == 0) begin
      r.n = 0; r.d = 1;
    end else begin
      g = refGcd(n, d);
      r.n = n / g; r.d = d / g;
    end
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Present one operand pair and wait for it to be accepted; the queue gets the model result.
  task automatic applyStimulus(input logic [W-1:0] n, input logic [W-1:0] d, input bit score);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < MAX_LAT) begin
      @(negedge clk);
      waited++;
    end
    checkVal("in_ready_before_drive", in_ready, 1'b1);
    in_num   = n;
    in_den   = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (score) sb.push_back(refModel(n, d));
  endtask

  // Wait for the result, compare it against the queue, optionally stall, then complete the handshake.
  task automatic checkOutput(input int exact_lat, input int hold);
    int   lat;
    exp_t e;
    lat = 1;
    while (!out_valid && lat < MAX_LAT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkVal("out_valid_within_bound", out_valid, 1'b1);
    if (!out_valid) return;
    checks++;
    assert (lat <= MAX_LAT) else begin
      errors++;
      $error("[TB] FAIL latency observed=%0d expected<=%0d", lat, MAX_LAT);
    end
    if (exact_lat > 0) checkVal("fast_latency", lat, exact_lat);
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=1", sb.size());
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkVal("s_num", s_num, e.n);
    checkVal("s_den", s_den, e.d);
    checkVal("err", err, e.e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 3) begin
        in_num = 5; in_den = 10; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      checkVal("hold_out_valid", out_valid, 1'b1);
      checkVal("hold_in_ready", in_ready, 1'b0);
      checkVal("hold_s_num", s_num, e.n);
      checkVal("hold_s_den", s_den, e.d);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkVal("post_handshake_out_valid", out_valid, 1'b0);
    checkVal("post_handshake_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_num = '0; in_den = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkVal("reset_in_ready", in_ready, 1'b1);
    checkVal("reset_out_valid", out_valid, 1'b0);
    checkVal("reset_s_num", s_num, '0);
    checkVal("reset_s_den", s_den, '0);
    checkVal("reset_err", err, 1'b0);

    applyStimulus(12, 18, 1'b1);             checkOutput(0, 0);
    applyStimulus(60, 60, 1'b1);             checkOutput(0, 0);
    applyStimulus(7, 13, 1'b1);              checkOutput(0, 0);
    applyStimulus(0, 5, 1'b1);               checkOutput(2, 0);
    applyStimulus(1024, 4096, 1'b1);         checkOutput(0, 0);
    applyStimulus(9, 0, 1'b1);               checkOutput(2, 0);
    applyStimulus(0, 0, 1'b1);               checkOutput(2, 0);
    applyStimulus(32'hFFFF_FFFF, 1, 1'b1);   checkOutput(0, 0);

    // Stall the consumer; a stray in_valid pulse during the stall must be ignored.
    applyStimulus(999000, 998001, 1'b1);     checkOutput(0, 10);
    repeat (4) begin
      @(negedge clk);
      checkVal("ignored_pulse_no_output", out_valid, 1'b0);
    end

    // A few random pairs sharing a common factor.
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] f, x, y;
      f = $urandom_range(1, 500);
      x = $urandom_range(0, 4000) * f;
      y = $urandom_range(1, 4000) * f;
      applyStimulus(x, y, 1'b1);
      checkOutput(0, 0);
    end

    // Reset in the middle of the GCD phase aborts the operation.
    applyStimulus(360, 840, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkVal("abort_out_valid", out_valid, 1'b0);
    checkVal("abort_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("abort_no_output", out_valid, 1'b0);
    applyStimulus(8, 12, 1'b1);              checkOutput(0, 0);

    checkVal("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
